// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer and the datapath controller
// that decodes its one-hot phase output.
package phase_sequencer_pkg;

    // One-hot phase encodings; the controller decodes these same constants.
    localparam logic [3:0] PH_IDLE = 4'b0000;
    localparam logic [3:0] PH_IF   = 4'b0001;
    localparam logic [3:0] PH_DE   = 4'b0010;
    localparam logic [3:0] PH_EX   = 4'b0100;
    localparam logic [3:0] PH_WB   = 4'b1000;

    // Width of the PC and breakpoint address buses.
    localparam int PC_W = 32;

    // Sequencer operating modes.
    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_INST  = 2'd2,
        MODE_PHASE = 2'd3
    } modeT;

    // Rotate to the phase that follows the given one (IF->DE->EX->WB->IF).
    function automatic logic [3:0] nextPhase(input logic [3:0] phase);
        return {phase[2:0], phase[3]};
    endfunction

endpackage

// File: rtl/phase_sequencer_retire_counter.sv
// retire_counter: free-running count of retired instructions. Advances once
// per enabled cycle and wraps from all-ones back to zero.
module retire_counter
    import phase_sequencer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count each enabled cycle; natural overflow gives the modulo wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: multicycle phase generator feeding the datapath
// controller. Issues IF/DE/EX/WB one cycle each under run, stop,
// instruction-step and phase-step control, and forces cstate to zero while
// paused so no strobe fires when the core is idle.
// Optional breakpoint halting is built when PHASE_SEQ_BREAK_EN is defined;
// otherwise pc/bp_addr/bp_valid are ignored and bp_hit is tied low.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             stop,
    input  logic             step_inst,
    input  logic             step_phase,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
    output logic [3:0]       cstate,
    output logic             running,
    output logic             busy,
    output logic             retire,
    output logic [CNT_W-1:0] inst_count,
    output logic             bp_hit
);

    // Registered sequencer state. r_pend is the next phase to issue and is
    // never zero; r_cstate equals r_pend on every issuing cycle, else zero.
    modeT       r_mode;
    logic [3:0] r_pend;
    logic [3:0] r_cstate;
    logic       r_stopReq;

    logic       w_idle;
    logic       w_accept;
    logic       w_bpTrigger;
    logic [3:0] w_pendNext;

    assign w_idle     = (r_mode == MODE_IDLE);
    // Stop outranks every start pulse, so a stop in IDLE masks them all.
    assign w_accept   = w_idle && !stop && (run || step_inst || step_phase);
    assign w_pendNext = nextPhase(r_pend);

    // Main sequencer FSM: mode transitions, phase rotation and stop handling.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mode    <= MODE_IDLE;
            r_pend    <= PH_IF;
            r_cstate  <= PH_IDLE;
            r_stopReq <= 1'b0;
        end else begin
            unique case (r_mode)
                MODE_IDLE: begin
                    r_stopReq <= 1'b0;
                    if (w_accept) begin
                        r_cstate <= r_pend;
                        if (run) begin
                            r_mode <= MODE_RUN;
                        end else if (step_inst) begin
                            r_mode <= MODE_INST;
                        end else begin
                            r_mode <= MODE_PHASE;
                        end
                    end
                end
                MODE_RUN: begin
                    if (w_bpTrigger) begin
                        // The IF just issued only reloads IR, so restarting at IF is safe.
                        r_mode    <= MODE_IDLE;
                        r_pend    <= PH_IF;
                        r_cstate  <= PH_IDLE;
                        r_stopReq <= 1'b0;
                    end else if ((r_cstate == PH_WB) && r_stopReq) begin
                        r_mode    <= MODE_IDLE;
                        r_pend    <= PH_IF;
                        r_cstate  <= PH_IDLE;
                        r_stopReq <= 1'b0;
                    end else begin
                        r_pend   <= w_pendNext;
                        r_cstate <= w_pendNext;
                        if (stop) begin
                            r_stopReq <= 1'b1;
                        end
                    end
                end
                MODE_INST: begin
                    if (r_cstate == PH_WB) begin
                        r_mode   <= MODE_IDLE;
                        r_pend   <= PH_IF;
                        r_cstate <= PH_IDLE;
                    end else begin
                        r_pend   <= w_pendNext;
                        r_cstate <= w_pendNext;
                    end
                end
                MODE_PHASE: begin
                    // Keep the partially executed instruction parked in r_pend.
                    r_mode   <= MODE_IDLE;
                    r_pend   <= w_pendNext;
                    r_cstate <= PH_IDLE;
                end
                default: begin
                    r_mode   <= MODE_IDLE;
                    r_pend   <= PH_IF;
                    r_cstate <= PH_IDLE;
                end
            endcase
        end
    end

`ifdef PHASE_SEQ_BREAK_EN
    logic r_firstAfterResume;
    logic r_bpHit;

    // Only the IF of an instruction fetched in RUN mode can hit, and never
    // the very first IF after a resume, so continuing from a breakpoint works.
    assign w_bpTrigger = (r_mode == MODE_RUN) && (r_cstate == PH_IF) && bp_valid
                         && (pc == bp_addr) && !r_firstAfterResume;

    // Track the resume window and the sticky breakpoint flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_firstAfterResume <= 1'b0;
            r_bpHit            <= 1'b0;
        end else begin
            if (w_accept) begin
                r_firstAfterResume <= 1'b1;
                r_bpHit            <= 1'b0;
            end else if (r_cstate == PH_IF) begin
                r_firstAfterResume <= 1'b0;
            end
            if (w_bpTrigger) begin
                r_bpHit <= 1'b1;
            end
        end
    end

    assign bp_hit = r_bpHit;
`else
    logic w_unusedBreakInputs;

    assign w_unusedBreakInputs = ^{pc, bp_addr, bp_valid};
    assign w_bpTrigger         = 1'b0;
    assign bp_hit              = 1'b0;
`endif

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retireCounter (
        .clock   (clock),
        .reset   (reset),
        .i_enable(retire),
        .o_count (inst_count)
    );

    assign cstate  = r_cstate;
    assign running = (r_mode == MODE_RUN);
    assign busy    = (r_pend != PH_IF) || (r_cstate != PH_IDLE);
    assign retire  = (r_cstate == PH_WB);

    // The pending phase is always exactly one legal phase.
    apPendOneHot: assert property (@(posedge clock) disable iff (!reset)
        $onehot(r_pend));

    // Whatever appears on cstate is the pending phase, or nothing.
    apIssueMatchesPend: assert property (@(posedge clock) disable iff (!reset)
        (r_cstate == PH_IDLE) || (r_cstate == r_pend));

    // A paused core never drives a phase.
    apIdleQuiet: assert property (@(posedge clock) disable iff (!reset)
        (r_mode == MODE_IDLE) |-> (r_cstate == PH_IDLE));

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: scenario bench for phase_sequencer. Each row of a
// scenario table drives the control pulses for one cycle and pushes the
// outputs expected one cycle later onto a scoreboard queue.
module tb_phase_sequencer;
    import phase_sequencer_pkg::*;

    localparam int CNT_W = 32;

    localparam logic [3:0] D_NONE = 4'b0000;
    localparam logic [3:0] D_RUN  = 4'b1000;
    localparam logic [3:0] D_STOP = 4'b0100;
    localparam logic [3:0] D_INST = 4'b0010;
    localparam logic [3:0] D_PH   = 4'b0001;

    logic             clock      = 1'b0;
    logic             reset      = 1'b0;
    logic             run        = 1'b0;
    logic             stop       = 1'b0;
    logic             step_inst  = 1'b0;
    logic             step_phase = 1'b0;
    logic [31:0]      pc         = 32'h0;
    logic [31:0]      bp_addr    = 32'h10;
    logic             bp_valid   = 1'b0;
    logic [3:0]       cstate;
    logic             running;
    logic             busy;
    logic             retire;
    logic [CNT_W-1:0] inst_count;
    logic             bp_hit;

    int               testsRun    = 0;
    int               testsFailed = 0;
    logic [CNT_W-1:0] modelCount  = '0;
    logic [7:0]       scoreboard[$];

    phase_sequencer #(
        .CNT_W(CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .stop      (stop),
        .step_inst (step_inst),
        .step_phase(step_phase),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
        .cstate    (cstate),
        .running   (running),
        .busy      (busy),
        .retire    (retire),
        .inst_count(inst_count),
        .bp_hit    (bp_hit)
    );

    // 10 ns system clock.
    always #5 clock = ~clock;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Row layout: {drive[3:0], cstate[3:0], running, busy, bp_hit}.
    function automatic logic [10:0] row(input logic [3:0] d, input logic [3:0] cs,
                                        input logic rn, input logic bz, input logic bp);
        return {d, cs, rn, bz, bp};
    endfunction

    // Expected output vector {cstate, running, busy, retire, bp_hit}.
    function automatic logic [7:0] expOf(input logic [10:0] r);
        return {r[6:3], r[2], r[1], (r[6:3] == PH_WB), r[0]};
    endfunction

    function automatic logic [3:0] phaseOf(input int n);
        logic [3:0] one;
        one = 4'b0001;
        return one << n;
    endfunction

    // Drive one cycle of pulses and record what must appear next cycle.
    task automatic applyStimulus(input logic [10:0] r);
        {run, stop, step_inst, step_phase} = r[10:7];
        scoreboard.push_back(expOf(r));
    endtask

    task automatic test_reset();
        @(negedge clock);
        testsRun++;
        if ({cstate, running, busy, retire, bp_hit} !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %b expected %b",
                     {cstate, running, busy, retire, bp_hit}, 8'h00);
        end
        testsRun++;
        if (inst_count !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_count: got %0d expected 0", inst_count);
        end
        reset = 1'b1;
    endtask

    task automatic test_run_stop();
        logic [10:0] tbl[$];
        logic [7:0]  expVec;
        for (int i = 0; i < 20; i++) begin
            tbl.push_back(row((i == 0) ? D_RUN : ((i == 19) ? D_STOP : D_NONE),
                              phaseOf(i % 4), 1'b1, 1'b1, 1'b0));
        end
        tbl.push_back(row(D_NONE, PH_IDLE, 1'b0, 1'b0, 1'b0));
        tbl.push_back(row(D_NONE, PH_IDLE, 1'b0, 1'b0, 1'b0));
        foreach (tbl[k]) begin
            applyStimulus(tbl[k]);
            @(negedge clock);
            expVec = scoreboard.pop_front();
            testsRun++;
            if ({cstate, running, busy, retire, bp_hit} !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL run_stop step %0d: got %b expected %b", k,
                         {cstate, running, busy, retire, bp_hit}, expVec);
            end
            testsRun++;
            if (inst_count !== modelCount) begin
                testsFailed++;
                $display("[TB] FAIL run_stop_count step %0d: got %0d expected %0d",
                         k, inst_count, modelCount);
            end
            if (expVec[7:4] == PH_WB) modelCount++;
        end
    endtask

    task automatic test_step_phase();
        logic [10:0] tbl[$];
        logic [7:0]  expVec;
        for (int k = 0; k < 12; k++) begin
            if (k % 3 == 0) tbl.push_back(row(D_PH, phaseOf(k / 3), 1'b0, 1'b1, 1'b0));
            else            tbl.push_back(row(D_NONE, PH_IDLE, 1'b0, (k / 3) != 3, 1'b0));
        end
        foreach (tbl[k]) begin
            applyStimulus(tbl[k]);
            @(negedge clock);
            expVec = scoreboard.pop_front();
            testsRun++;
            if ({cstate, running, busy, retire, bp_hit} !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL step_phase step %0d: got %b expected %b", k,
                         {cstate, running, busy, retire, bp_hit}, expVec);
            end
            testsRun++;
            if (inst_count !== modelCount) begin
                testsFailed++;
                $display("[TB] FAIL step_phase_count step %0d: got %0d expected %0d",
                         k, inst_count, modelCount);
            end
            if (expVec[7:4] == PH_WB) modelCount++;
        end
    endtask

    task automatic test_resume_step_inst();
        logic [10:0] tbl[$];
        logic [7:0]  expVec;
        tbl = '{row(D_PH,   PH_IF,   1'b0, 1'b1, 1'b0),
                row(D_NONE, PH_IDLE, 1'b0, 1'b1, 1'b0),
                row(D_PH,   PH_DE,   1'b0, 1'b1, 1'b0),
                row(D_NONE, PH_IDLE, 1'b0, 1'b1, 1'b0),
                row(D_INST, PH_EX,   1'b0, 1'b1, 1'b0),
                row(D_NONE, PH_WB,   1'b0, 1'b1, 1'b0),
                row(D_NONE, PH_IDLE, 1'b0, 1'b0, 1'b0),
                row(D_NONE, PH_IDLE, 1'b0, 1'b0, 1'b0)};
        foreach (tbl[k]) begin
            applyStimulus(tbl[k]);
            @(negedge clock);
            expVec = scoreboard.pop_front();
            testsRun++;
            if ({cstate, running, busy, retire, bp_hit} !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL resume_step_inst step %0d: got %b expected %b", k,
                         {cstate, running, busy, retire, bp_hit}, expVec);
            end
            testsRun++;
            if (inst_count !== modelCount) begin
                testsFailed++;
                $display("[TB] FAIL resume_step_inst_count step %0d: got %0d expected %0d",
                         k, inst_count, modelCount);
            end
            if (expVec[7:4] == PH_WB) modelCount++;
        end
    endtask

    task automatic test_resume_run();
        logic [10:0] tbl[$];
        logic [7:0]  expVec;
        tbl = '{row(D_PH,   PH_IF,   1'b0, 1'b1, 1'b0),
                row(D_NONE, PH_IDLE, 1'b0, 1'b1, 1'b0),
                row(D_RUN,  PH_DE,   1'b1, 1'b1, 1'b0),
                row(D_NONE, PH_EX,   1'b1, 1'b1, 1'b0),
                row(D_NONE, PH_WB,   1'b1, 1'b1, 1'b0),
                row(D_NONE, PH_IF,   1'b1, 1'b1, 1'b0),
                row(D_NONE, PH_DE,   1'b1, 1'b1, 1'b0),
                row(D_STOP, PH_EX,   1'b1, 1'b1, 1'b0),
                row(D_NONE, PH_WB,   1'b1, 1'b1, 1'b0),
                row(D_NONE, PH_IDLE, 1'b0, 1'b0, 1'b0),
                row(D_NONE, PH_IDLE, 1'b0, 1'b0, 1'b0)};
        foreach (tbl[k]) begin
            applyStimulus(tbl[k]);
            @(negedge clock);
            expVec = scoreboard.pop_front();
            testsRun++;
            if ({cstate, running, busy, retire, bp_hit} !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL resume_run step %0d: got %b expected %b", k,
                         {cstate, running, busy, retire, bp_hit}, expVec);
            end
            testsRun++;
            if (inst_count !== modelCount) begin
                testsFailed++;
                $display("[TB] FAIL resume_run_count step %0d: got %0d expected %0d",
                         k, inst_count, modelCount);
            end
            if (expVec[7:4] == PH_WB) modelCount++;
        end
    endtask

    task automatic test_priority();
        logic [10:0] tbl[$];
        logic [7:0]  expVec;
        tbl = '{row(D_STOP,          PH_IDLE, 1'b0, 1'b0, 1'b0),
                row(D_STOP | D_RUN,  PH_IDLE, 1'b0, 1'b0, 1'b0),
                row(D_RUN | D_INST,  PH_IF,   1'b1, 1'b1, 1'b0),
                row(D_PH,            PH_DE,   1'b1, 1'b1, 1'b0),
                row(D_STOP,          PH_EX,   1'b1, 1'b1, 1'b0),
                row(D_NONE,          PH_WB,   1'b1, 1'b1, 1'b0),
                row(D_NONE,          PH_IDLE, 1'b0, 1'b0, 1'b0),
                row(D_INST | D_PH,   PH_IF,   1'b0, 1'b1, 1'b0),
                row(D_RUN,           PH_DE,   1'b0, 1'b1, 1'b0),
                row(D_INST,          PH_EX,   1'b0, 1'b1, 1'b0),
                row(D_NONE,          PH_WB,   1'b0, 1'b1, 1'b0),
                row(D_NONE,          PH_IDLE, 1'b0, 1'b0, 1'b0),
                row(D_NONE,          PH_IDLE, 1'b0, 1'b0, 1'b0)};
        foreach (tbl[k]) begin
            applyStimulus(tbl[k]);
            @(negedge clock);
            expVec = scoreboard.pop_front();
            testsRun++;
            if ({cstate, running, busy, retire, bp_hit} !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL priority step %0d: got %b expected %b", k,
                         {cstate, running, busy, retire, bp_hit}, expVec);
            end
            testsRun++;
            if (inst_count !== modelCount) begin
                testsFailed++;
                $display("[TB] FAIL priority_count step %0d: got %0d expected %0d",
                         k, inst_count, modelCount);
            end
            if (expVec[7:4] == PH_WB) modelCount++;
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] tbl[$];
        logic [7:0]  expVec;
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        @(negedge clock);
        testsRun++;
        if (cstate !== PH_EX) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_pre: got %b expected %b", cstate, PH_EX);
        end
        #2 reset = 1'b0;
        #1;
        testsRun++;
        if ({cstate, running, busy, retire, bp_hit} !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_async: got %b expected %b",
                     {cstate, running, busy, retire, bp_hit}, 8'h00);
        end
        testsRun++;
        if (inst_count !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_count: got %0d expected 0", inst_count);
        end
        modelCount = '0;
        @(negedge clock);
        reset = 1'b1;
        tbl = '{row(D_NONE, PH_IDLE, 1'b0, 1'b0, 1'b0),
                row(D_NONE, PH_IDLE, 1'b0, 1'b0, 1'b0)};
        foreach (tbl[k]) begin
            applyStimulus(tbl[k]);
            @(negedge clock);
            expVec = scoreboard.pop_front();
            testsRun++;
            if ({cstate, running, busy, retire, bp_hit} !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL reset_mid_idle step %0d: got %b expected %b", k,
                         {cstate, running, busy, retire, bp_hit}, expVec);
            end
            testsRun++;
            if (inst_count !== modelCount) begin
                testsFailed++;
                $display("[TB] FAIL reset_mid_idle_count step %0d: got %0d expected %0d",
                         k, inst_count, modelCount);
            end
        end
    endtask

`ifdef PHASE_SEQ_BREAK_EN
    task automatic test_breakpoint();
        logic [10:0] tbl[$];
        logic [7:0]  expVec;
        pc       = 32'h0;
        bp_addr  = 32'h10;
        bp_valid = 1'b1;
        tbl.push_back(row(D_RUN, PH_IF, 1'b1, 1'b1, 1'b0));
        for (int i = 1; i <= 16; i++) begin
            tbl.push_back(row(D_NONE, phaseOf(i % 4), 1'b1, 1'b1, 1'b0));
        end
        tbl.push_back(row(D_NONE, PH_IDLE, 1'b0, 1'b0, 1'b1));
        tbl.push_back(row(D_RUN,  PH_IF,   1'b1, 1'b1, 1'b0));
        tbl.push_back(row(D_NONE, PH_DE,   1'b1, 1'b1, 1'b0));
        tbl.push_back(row(D_NONE, PH_EX,   1'b1, 1'b1, 1'b0));
        tbl.push_back(row(D_NONE, PH_WB,   1'b1, 1'b1, 1'b0));
        tbl.push_back(row(D_NONE, PH_IF,   1'b1, 1'b1, 1'b0));
        tbl.push_back(row(D_NONE, PH_DE,   1'b1, 1'b1, 1'b0));
        tbl.push_back(row(D_STOP, PH_EX,   1'b1, 1'b1, 1'b0));
        tbl.push_back(row(D_NONE, PH_WB,   1'b1, 1'b1, 1'b0));
        tbl.push_back(row(D_NONE, PH_IDLE, 1'b0, 1'b0, 1'b0));
        foreach (tbl[k]) begin
            applyStimulus(tbl[k]);
            @(negedge clock);
            expVec = scoreboard.pop_front();
            testsRun++;
            if ({cstate, running, busy, retire, bp_hit} !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL breakpoint step %0d pc %h: got %b expected %b", k, pc,
                         {cstate, running, busy, retire, bp_hit}, expVec);
            end
            testsRun++;
            if (inst_count !== modelCount) begin
                testsFailed++;
                $display("[TB] FAIL breakpoint_count step %0d: got %0d expected %0d",
                         k, inst_count, modelCount);
            end
            if (expVec[7:4] == PH_WB) begin
                modelCount++;
                pc = pc + 32'd4;
            end
        end
        bp_valid = 1'b0;
    endtask
`endif

    task automatic test_wrap();
        logic [10:0] tbl[$];
        logic [7:0]  expVec;
        force dut.u_retireCounter.r_count = {CNT_W{1'b1}};
        @(negedge clock);
        release dut.u_retireCounter.r_count;
        modelCount = {CNT_W{1'b1}};
        tbl = '{row(D_INST, PH_IF,   1'b0, 1'b1, 1'b0),
                row(D_NONE, PH_DE,   1'b0, 1'b1, 1'b0),
                row(D_NONE, PH_EX,   1'b0, 1'b1, 1'b0),
                row(D_NONE, PH_WB,   1'b0, 1'b1, 1'b0),
                row(D_NONE, PH_IDLE, 1'b0, 1'b0, 1'b0),
                row(D_NONE, PH_IDLE, 1'b0, 1'b0, 1'b0)};
        foreach (tbl[k]) begin
            applyStimulus(tbl[k]);
            @(negedge clock);
            expVec = scoreboard.pop_front();
            testsRun++;
            if ({cstate, running, busy, retire, bp_hit} !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL wrap step %0d: got %b expected %b", k,
                         {cstate, running, busy, retire, bp_hit}, expVec);
            end
            testsRun++;
            if (inst_count !== modelCount) begin
                testsFailed++;
                $display("[TB] FAIL wrap_count step %0d: got %h expected %h",
                         k, inst_count, modelCount);
            end
            if (expVec[7:4] == PH_WB) modelCount++;
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_run_stop();
        test_step_phase();
        test_resume_step_inst();
        test_resume_run();
        test_priority();
        test_reset_mid();
`ifdef PHASE_SEQ_BREAK_EN
        test_breakpoint();
`endif
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Multicycle phase generator that sits directly upstream of the datapath controller; drives its 4-bit one-hot `cstate`.
- Sequences IF→DE→EX→WB per instruction under run, stop, instruction-step and phase-step control from the debug/console logic.
- Counts retired instructions.
- Guarantees `cstate` is 0000 whenever the core is paused, so no load/write strobe is generated while idle.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  single-cycle pulse: enter continuous run.
- stop  in  1  single-cycle pulse: halt after the current instruction completes.
- step_inst  in  1  single-cycle pulse: execute the remaining phases of one instruction, then pause.
- step_phase  in  1  single-cycle pulse: issue exactly one phase, then pause.
- pc  in  32  current PC register value (breakpoint compare only).
- bp_addr  in  32  breakpoint address (breakpoint feature only).
- bp_valid  in  1  breakpoint enable (breakpoint feature only).
- cstate  out  4  0001 IF, 0010 DE, 0100 EX, 1000 WB, 0000 paused.
- running  out  1  1 while in RUN mode.
- busy  out  1  1 while an instruction is partially executed (pending phase ≠ IF) or `cstate` ≠ 0.
- retire  out  1  high during every WB cycle.
- inst_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.
- bp_hit  out  1  sticky breakpoint flag (breakpoint feature only; tied 0 otherwise).

Behaviour:
- Registers: `mode` {IDLE, RUN, INST, PHASE}; `pend` = next phase to issue (one-hot, never 0000); `issue` = 1 when `cstate` = `pend` this cycle.
- Reset (asynchronous, reset = 0):
  - mode = IDLE, pend = IF, issue = 0.
  - cstate = 0000, running = 0, busy = 0, retire = 0, inst_count = 0, bp_hit = 0.
- Phase order: IF→DE→EX→WB→IF. Every phase lasts exactly one cycle; `pend` rotates after each issued phase.
- IDLE (`cstate` = 0000): `pend` is held.
  - run → mode RUN.
  - step_inst → mode INST.
  - step_phase → mode PHASE.
  - First phase (= `pend`) appears on `cstate` the cycle after the pulse (latency 1).
- RUN:
  - Issues phases back to back, one per cycle.
  - A stop pulse sets `stop_req`.
  - At a WB cycle with `stop_req` set: return to IDLE with pend = IF, and clear `stop_req`.
- INST: issues phases until and including WB, then returns to IDLE.
- PHASE: issues one phase, then returns to IDLE. A partially executed instruction is kept in `pend`; `busy` stays 1.
- Pulses arriving while mode ≠ IDLE:
  - run, step_inst and step_phase are ignored.
  - stop is honoured only in RUN.
  - stop in IDLE is ignored.
- Simultaneous pulses in IDLE, priority: stop > run > step_inst > step_phase.
- Resume from a mid-instruction pause:
  - run or step_inst continues from `pend`; no phase is re-issued.
  - step_inst completes only the remaining phases.
- inst_count: increments on the clock edge ending each WB cycle; wraps all-ones → 0.
- retire = (cstate == 1000), combinational from registered state.
- running = (mode == RUN).
- reset asserted mid-instruction: immediate return to reset values; the partial instruction is abandoned.

Optional Feature:
- Macro: PHASE_SEQ_BREAK_EN.
- Defined:
  - During an IF cycle in RUN mode, if bp_valid and pc == bp_addr and `first_after_resume` = 0:
    - Set bp_hit.
    - Go to IDLE with pend = IF; the IF just issued is harmless because it only reloads IR.
  - `first_after_resume` is set by any run/step pulse accepted from IDLE and cleared after the first IF cycle, so resuming at a breakpoint does not re-trigger it.
  - bp_hit is cleared by the next accepted run or step pulse.
  - Breakpoints are not checked in INST or PHASE modes.
- Undefined: bp_addr, bp_valid and pc are unused; bp_hit is tied to 0.

Decomposition:
- Shared package/header:
  - Phase encodings PH_IDLE=4'b0000, PH_IF=4'b0001, PH_DE=4'b0010, PH_EX=4'b0100, PH_WB=4'b1000. The controller decodes these same constants.
  - Mode encodings.
- One natural sub-module: `retire_counter` (CNT_W-bit wrap counter with enable = retire). The FSM stays in phase_sequencer.

Test Plan:
- Release reset, pulse run → cstate = 0001, 0010, 0100, 1000, 0001… from the next cycle. running = 1. inst_count = 3 after 12 phase cycles.
- Pulse stop during EX of the 5th instruction → WB completes, then cstate = 0000, running = 0, busy = 0, inst_count = 5.
- From IDLE, four step_phase pulses 3 cycles apart → exactly one phase each (0001, 0010, 0100, 1000), 0000 in between. busy = 1 until WB, then 0.
- step_phase twice (IF, DE), then step_inst → EX, WB only, then IDLE. inst_count +1.
- Assert reset during EX in RUN → cstate = 0000 asynchronously. After release, idle. inst_count = 0.
- With PHASE_SEQ_BREAK_EN: bp_addr = 0x10, bp_valid = 1, run from pc = 0 →
  - Halts after IF at pc = 0x10; bp_hit = 1.
  - Next run → bp_hit = 0; execution proceeds past 0x10 without re-triggering.
  - Preset inst_count near all-ones (via force) → wraps to 0 on the next WB.
